// File: rtl/systolic_arb_pkg.sv
// Shared constants and width helpers for the systolic engine arbiter.
package systolic_arb_pkg;

  localparam int unsigned STAT_W = 16;

  // Client index width; never narrower than one bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flat width of one ROWS x ROWS A operand.
  function automatic int unsigned a_flat_w(input int unsigned rows, input int unsigned width);
    return rows * rows * width;
  endfunction

  // Flat width of one ROWS x COLS B operand.
  function automatic int unsigned b_flat_w(input int unsigned rows, input int unsigned cols,
                                           input int unsigned width);
    return rows * cols * width;
  endfunction

  // Flat width of one ROWS x COLS result matrix.
  function automatic int unsigned c_flat_w(input int unsigned rows, input int unsigned cols,
                                           input int unsigned acc_width);
    return rows * cols * acc_width;
  endfunction

endpackage

// File: rtl/systolic_tag_fifo.sv
// In-order tag FIFO recording which client owns each in-flight operation.
// DEPTH must be a power of two so the pointers wrap naturally.
module systolic_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/systolic_arbiter.sv
// Round-robin sharing of one systolic matmul engine between NREQ clients,
// with in-order routing of results back to their owners.
// Optional macro SYSTOLIC_ARB_STATS_EN adds per-client accept counters
// (stat_grants) and a stall-cycle counter (stat_stall).
module systolic_arbiter
  import systolic_arb_pkg::*;
#(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned COLS         = 2,
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned ACC_WIDTH    = 9,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NREQ-1:0]                                req_valid,
  output logic [NREQ-1:0]                                req_ready,
  input  logic [NREQ*a_flat_w(ROWS, WIDTH)-1:0]          req_a,
  input  logic [NREQ*b_flat_w(ROWS, COLS, WIDTH)-1:0]    req_b,
  output logic [NREQ-1:0]                                rsp_valid,
  output logic [c_flat_w(ROWS, COLS, ACC_WIDTH)-1:0]     rsp_c,
  output logic [a_flat_w(ROWS, WIDTH)-1:0]               eng_a,
  output logic [b_flat_w(ROWS, COLS, WIDTH)-1:0]         eng_b,
  output logic                                           eng_in_valid,
  input  logic                                           eng_in_ready,
  input  logic [c_flat_w(ROWS, COLS, ACC_WIDTH)-1:0]     eng_c,
  input  logic                                           eng_out_valid,
  output logic                                           busy,
  output logic                                           err_unexpected
`ifdef SYSTOLIC_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]                         stat_grants,
  output logic [STAT_W-1:0]                              stat_stall
`endif
);

  localparam int unsigned TAG_W = tag_w(NREQ);
  localparam int unsigned AW    = a_flat_w(ROWS, WIDTH);
  localparam int unsigned BW    = b_flat_w(ROWS, COLS, WIDTH);
  localparam int unsigned CW    = c_flat_w(ROWS, COLS, ACC_WIDTH);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             accept, pop;
  logic             fifo_full, fifo_empty;
  logic [TAG_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [CW-1:0]    rsp_c_q, rsp_c_d;
  logic             err_q, err_d;

  // Round-robin search: indices at/after rr_ptr first, then the wrapped lower ones.
  // Gated by rst_n so nothing is offered to the engine while reset is held.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i] && (TAG_W'(i) >= rr_ptr_q)) begin
        gnt_any = 1'b1;
        gnt_idx = TAG_W'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i] && (TAG_W'(i) < rr_ptr_q)) begin
        gnt_any = 1'b1;
        gnt_idx = TAG_W'(i);
      end
    end
    if (fifo_full || !rst_n) gnt_any = 1'b0;
  end

  // Operand mux and per-client ready; zero operands when nothing is granted.
  always_comb begin
    eng_a     = '0;
    eng_b     = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_any && (gnt_idx == TAG_W'(i))) begin
        eng_a        = req_a[i*AW +: AW];
        eng_b        = req_b[i*BW +: BW];
        req_ready[i] = eng_in_ready;
      end
    end
  end

  assign eng_in_valid = gnt_any;
  assign accept       = gnt_any & eng_in_ready;
  assign pop          = eng_out_valid & ~fifo_empty;

  systolic_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   (gnt_idx),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy = (fifo_count != '0);

  // Pointer moves to the slot after the accepted client, wrapping at NREQ.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
    end
  end

  // Response next-state: route popped result to the head owner; flag orphan results.
  always_comb begin
    rsp_valid_d = '0;
    rsp_c_d     = rsp_c_q;
    err_d       = err_q | (eng_out_valid & fifo_empty);
    if (pop) begin
      rsp_c_d = eng_c;
      for (int unsigned i = 0; i < NREQ; i++) begin
        rsp_valid_d[i] = (fifo_head == TAG_W'(i));
      end
    end
  end

  // Arbitration pointer and registered response stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_c_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_c          = rsp_c_q;
  assign err_unexpected = err_q;

`ifdef SYSTOLIC_ARB_STATS_EN
  logic [STAT_W-1:0] grants_q [NREQ];
  logic [STAT_W-1:0] stall_q;

  // Saturating accept counters per client and stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) grants_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (accept && (gnt_idx == TAG_W'(i)) && (grants_q[i] != '1)) begin
          grants_q[i] <= grants_q[i] + STAT_W'(1);
        end
      end
      if ((|req_valid) && !accept && (stall_q != '1)) stall_q <= stall_q + STAT_W'(1);
    end
  end

  // Flatten the per-client counters onto the output bus.
  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NREQ; i++) stat_grants[i*STAT_W +: STAT_W] = grants_q[i];
  end

  assign stat_stall = stall_q;
`endif

endmodule

// File: doc/systolic_arbiter.md
Name: systolic_arbiter

Overview:
- Shares one systolic matrix-multiply engine between NREQ requesters.
- Round-robin arbitration onto the engine input handshake.
- Records the client index of each accepted operation in an in-order tag FIFO, then routes each engine result back to its owner as a one-cycle response pulse.
- Sits between client blocks (DMA or command units) and the systolic engine.

Parameters:
- NREQ, 2, number of requesting clients (2..8).
- ROWS, 2, engine array rows; A operand is ROWS x ROWS.
- COLS, 2, engine array columns; B and C are ROWS x COLS.
- WIDTH, 4, operand element width.
- ACC_WIDTH, 9, result element width.
- MAX_INFLIGHT, 4, tag FIFO depth, i.e. maximum accepted-but-unreturned operations (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-client operation valid.
- req_ready  out  NREQ  per-client accept; at most one bit high per cycle.
- req_a  in  NREQ*ROWS*ROWS*WIDTH  client A matrices; client i occupies slice i.
- req_b  in  NREQ*ROWS*COLS*WIDTH  client B matrices; client i occupies slice i.
- rsp_valid  out  NREQ  one-hot result pulse to the owning client.
- rsp_c  out  ROWS*COLS*ACC_WIDTH  result matrix, shared by all clients.
- eng_a  out  ROWS*ROWS*WIDTH  A operand to the engine.
- eng_b  out  ROWS*COLS*WIDTH  B operand to the engine.
- eng_in_valid  out  1  engine input valid.
- eng_in_ready  in  1  engine input ready.
- eng_c  in  ROWS*COLS*ACC_WIDTH  engine result.
- eng_out_valid  in  1  engine result valid; single pulse, no backpressure.
- busy  out  1  high while FIFO non-empty.
- err_unexpected  out  1  sticky error flag.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_c=0, eng_in_valid=0, busy=0, err_unexpected=0, rr_ptr=0, FIFO empty.
- Arbitration is combinational.
  - grant = first set bit of req_valid searching from rr_ptr upward, wrapping modulo NREQ.
  - The grant is suppressed when the FIFO is full.
- eng_in_valid = |req_valid & !full.
- eng_a and eng_b mux the granted client's slices; they are 0 when there is no grant.
- req_ready[i] = grant[i] & eng_in_ready.
- Accept = eng_in_valid & eng_in_ready. On accept:
  - push granted index into the FIFO;
  - rr_ptr <= granted index + 1, mod NREQ.
- Without an accept, rr_ptr holds.
- Full blocks issue even if eng_out_valid pops in the same cycle. There is no combinational path from eng_out_valid to req_ready.
- Response stage is registered, 1 cycle latency. When eng_out_valid is high and the FIFO is non-empty:
  - next cycle rsp_valid = onehot(FIFO head), rsp_c = eng_c;
  - pop the head.
- rsp_c holds its last value when idle. rsp_valid is low in every cycle without a pop.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo MAX_INFLIGHT.
- eng_out_valid with the FIFO empty: no response is produced and err_unexpected is set. It clears only on reset.
- busy = FIFO count != 0, registered.
- Reset mid-operation: all state clears immediately. The engine shares rst_n, so no stale results arrive. Clients must reissue.
- No starvation: a continuously asserting client is granted within NREQ accepts.

Optional Feature:
- Macro: SYSTOLIC_ARB_STATS_EN.
- With the macro defined:
  - adds output stat_grants, NREQ*16 bits: one saturating 16-bit accept counter per client, reset to 0;
  - adds output stat_stall, 16 bits: saturating count of cycles with |req_valid and no accept (full or engine not ready).
- Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package systolic_arb_pkg:
  - TAG_W = $clog2(NREQ) helper function;
  - STAT_W = 16;
  - localparam helpers for A/B/C flat widths.
- Sub-module systolic_tag_fifo:
  - parameterised depth and width;
  - push, pop, head, full, empty, count;
  - async active-low reset.
- Arbitration, operand mux and response stage stay in the top module.

Test Plan:
- Single client: client 0 sends A=I, B=I → one req_ready pulse; one cycle after eng_out_valid, rsp_valid=2'b01 and rsp_c = I (1,0,0,1).
- Round-robin: both clients hold valid.
  - Client 0 sends A=[[1,2],[3,4]], B=I; client 1 sends A=ones, B=all 2s.
  - Grant order 0,1,0,1.
  - Responses alternate 2'b01 with C=[[1,2],[3,4]] and 2'b10 with C=all 4s.
- FIFO full: model the engine with eng_in_ready=1 and no eng_out_valid; issue 5 requests.
  - Exactly 4 are accepted, then eng_in_valid=0.
  - One eng_out_valid pulse → the 5th is accepted on the following cycle.
- Engine backpressure: eng_in_ready=0 for 3 cycles with client 1 valid.
  - No accept and rr_ptr unchanged.
  - Client 1 is accepted on the first ready cycle.
- Error: eng_out_valid while empty → err_unexpected=1, rsp_valid stays 0, and the flag persists until rst_n=0.
- Reset mid-flight: 2 ops outstanding, assert rst_n low → busy=0, req_ready=0 and FIFO empty immediately; stats counters (SYSTOLIC_ARB_STATS_EN) read 0.
